mpsoc_riscv_trace_term_monitor: RTL
===================================

// Module: mpsoc_riscv_trace_term_monitor
// PURPOSE
//   Synthesizable N-core trace monitor for MPSoC-RISCV sim/emulation builds. Shadows x3 (a0-style arg
//   reg) per core, decodes marker insns (exit, putc) from retirement trace, collects exit codes, and
//   streams putc characters via one shared FIFO. Signals global done once all cores exit and output
//   drains; watchdog flags hangs. Successor to per-core monitors: parametrised core count, handshaked.
// PARAMETERS
//   NUM_CORES       8             cores observed (1..64)
//   XLEN            32            writeback data width
//   FIFO_DEPTH      16            char FIFO entries, power of 2 >= 2
//   EXIT_INSN       32'h00100013  addi x0,x0,1 : exit, code = shadow x3[7:0]
//   PUTC_INSN       32'h00400013  addi x0,x0,4 : putc, char = shadow x3[7:0]
//   TIMEOUT_CYCLES  1000000       idle cycles before timeout; 0 disables
// PORTS
//   clk            in   1              clock
//   rst_n          in   1              async active-low reset
//   trace_valid    in   NUM_CORES      per-core retire strobe
//   trace_insn     in   NUM_CORES*32   retired insn
//   trace_wben     in   NUM_CORES      writeback enable
//   trace_wbreg    in   NUM_CORES*5    writeback reg index
//   trace_wbdata   in   NUM_CORES*XLEN writeback data
//   char_valid     out  1              char available
//   char_ready     in   1              consumer accepts
//   char_core      out  6              source core id
//   char_data      out  8              character
//   core_done      out  NUM_CORES      sticky per-core exit seen
//   exit_code      out  NUM_CORES*8    captured exit codes
//   all_done       out  1              all exited, FIFO empty
//   exit_error     out  1              any exit_code != 0 (valid with all_done)
//   char_overflow  out  1              sticky: putc dropped
//   timeout        out  1              sticky watchdog fire
// BEHAVIOUR
//   Reset: all outputs 0; shadows, holding regs, FIFO ptrs, counter cleared; FSM=IDLE.
//   Shadow: valid&wben&wbreg==3 -> shadow[i]<=wbdata next cycle. Markers read registered shadow
//     (value before current cycle); markers write x0, so no same-core conflict.
//   Exit: valid&insn==EXIT_INSN&!core_done[i] -> core_done[i]=1, exit_code[i]=shadow[7:0] next cycle;
//     repeat exits ignored. Retires from done cores still update shadow, not reported.
//   Putc: valid&insn==PUTC_INSN -> load per-core 1-entry hold reg. Hold reg full on new putc -> char
//     dropped, char_overflow=1 (sticky). Same-cycle putc of a freed hold reg is accepted.
//   Arbiter: round-robin among full hold regs, one FIFO write per cycle when FIFO not full; pointer
//     advances past granted core. Min latency putc retire -> char_valid: 3 cycles (hold, FIFO, out).
//   FIFO: FWFT output; pop on char_valid&char_ready; simultaneous push+pop when full allowed
//     (only if pop); occupancy counter FIFO_DEPTH+1 states, ptrs wrap mod FIFO_DEPTH.
//   Output stable: char_core/char_data held while char_valid&!char_ready.
//   Watchdog: counter clears on any trace_valid; saturating increment else; reaching TIMEOUT_CYCLES
//     sets timeout (sticky), FSM->TIMEOUT. Counting only in RUN/DRAIN.
//   FSM: IDLE -(any trace_valid)-> RUN -(&core_done)-> DRAIN -(hold regs & FIFO empty)-> DONE.
//     RUN/DRAIN -(watchdog)-> TIMEOUT. DONE/TIMEOUT terminal until reset; FIFO keeps draining in both.
//   all_done=1 only in DONE, registered; exit_error = |exit_code, registered with all_done.
//   Mid-operation rst_n low: immediate clear of all state and outputs; queued chars lost.
// TESTING
//   T1 1 core: write x3=0x41, PUTC, write x3=0, EXIT, char_ready=1 -> char 'A' core 0 once, then
//      all_done=1, exit_error=0, exit_code[0]=0.
//   T2 4 cores PUTC same cycle, x3=0x30+i -> chars '0','1','2','3' in RR order, no overflow.
//   T3 char_ready=0, 17 putcs from core 0 (DEPTH 16) -> FIFO full + hold full, next putc sets
//      char_overflow; release -> exactly 17 chars in order.
//   T4 core 2 EXIT with x3=5, others 0 -> exit_code[2]=5, exit_error=1 at all_done; second EXIT core 2
//      with x3=9 -> exit_code unchanged.
//   T5 TIMEOUT_CYCLES=100, one retire then silence -> timeout=1 exactly 100 cycles later, all_done=0.
//   T6 rst_n low during DRAIN with 5 queued chars -> all outputs 0 same edge; FSM IDLE after release.

Source files
------------

// File: rtl/mpsoc_riscv_trace_term_monitor.sv
// mpsoc_riscv_trace_term_monitor
// Watches the retirement trace of NUM_CORES RISC-V cores. Keeps a shadow of
// the low byte of x3 per core, decodes the exit/putc marker instructions,
// captures exit codes and funnels putc characters through a shared
// first-word-fall-through FIFO with a registered output stage. An FSM raises
// all_done once every core has exited and all characters have drained.
// A watchdog flags a trace that has gone silent.
module mpsoc_riscv_trace_term_monitor #(
   parameter int unsigned NUM_CORES      = 8,
   parameter int unsigned XLEN           = 32,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter logic [31:0] EXIT_INSN      = 32'h00100013,
   parameter logic [31:0] PUTC_INSN      = 32'h00400013,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CORES-1:0]        trace_valid,
   input  logic [NUM_CORES*32-1:0]     trace_insn,
   input  logic [NUM_CORES-1:0]        trace_wben,
   input  logic [NUM_CORES*5-1:0]      trace_wbreg,
   input  logic [NUM_CORES*XLEN-1:0]   trace_wbdata,
   output logic                        char_valid,
   input  logic                        char_ready,
   output logic [5:0]                  char_core,
   output logic [7:0]                  char_data,
   output logic [NUM_CORES-1:0]        core_done,
   output logic [NUM_CORES*8-1:0]      exit_code,
   output logic                        all_done,
   output logic                        exit_error,
   output logic                        char_overflow,
   output logic                        timeout
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_DONE    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   // Only the low byte of x3 is ever observed by a marker, so that is all we shadow.
   logic [7:0]            shadow_r [NUM_CORES];
   logic [NUM_CORES-1:0]  core_done_r;
   logic [NUM_CORES*8-1:0] exit_code_r;

   logic [NUM_CORES-1:0]  hold_full_r;
   logic [7:0]            hold_data_r [NUM_CORES];
   logic                  char_overflow_r;
   logic [5:0]            rr_ptr_r;

   logic [13:0]           fifo_mem_r [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic [CW-1:0]         count_r;
   logic                  char_valid_r;
   logic [5:0]            char_core_r;
   logic [7:0]            char_data_r;

   state_t                state_r;
   logic [31:0]           wd_cnt_r;
   logic                  all_done_r;
   logic                  exit_error_r;
   logic                  timeout_r;

   logic [NUM_CORES-1:0]  putc_s;
   logic [NUM_CORES-1:0]  exit_s;
   logic [NUM_CORES-1:0]  freed_s;
   logic                  any_valid_s;
   logic [63:0]           hold_pad_s;
   logic [6:0]            cand_s;
   logic                  grant_vld_s;
   logic [5:0]            grant_idx_s;
   logic [5:0]            rr_next_s;
   logic [7:0]            push_data_s;
   logic                  pop_s;
   logic                  push_s;
   logic [PW-1:0]         rd_next_s;
   logic [CW-1:0]         avail_s;
   logic                  drained_s;
   logic [31:0]           wd_next_s;
   logic                  wd_fire_s;
   logic                  unused_wbdata_s;

   // Marker decode per core
   always_comb begin
      putc_s      = {NUM_CORES{1'b0}};
      exit_s      = {NUM_CORES{1'b0}};
      any_valid_s = |trace_valid;
      for (int i = 0; i < NUM_CORES; i++) begin
         putc_s[i] = trace_valid[i] && (trace_insn[i*32 +: 32] == PUTC_INSN);
         exit_s[i] = trace_valid[i] && (trace_insn[i*32 +: 32] == EXIT_INSN);
      end
   end

   // Upper writeback bits never reach a marker; fold them into a sink
   always_comb begin
      unused_wbdata_s = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         unused_wbdata_s = unused_wbdata_s ^ (^trace_wbdata[i*XLEN+8 +: XLEN-8]);
      end
   end

   // Round-robin search for the first full hold register at or after rr_ptr_r
   always_comb begin
      hold_pad_s  = 64'(hold_full_r);
      grant_vld_s = 1'b0;
      grant_idx_s = 6'd0;
      cand_s      = 7'd0;
      for (int k = 0; k < NUM_CORES; k++) begin
         cand_s = {1'b0, rr_ptr_r} + 7'(k);
         if (cand_s >= 7'(NUM_CORES)) begin
            cand_s = cand_s - 7'(NUM_CORES);
         end else begin
            cand_s = cand_s;
         end
         if (!grant_vld_s && hold_pad_s[cand_s[5:0]]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = cand_s[5:0];
         end else begin
            grant_vld_s = grant_vld_s;
         end
      end
   end

   // FIFO handshake, granted data mux and hold-register release
   always_comb begin
      pop_s       = char_valid_r && char_ready;
      push_s      = grant_vld_s && ((count_r != CW'(FIFO_DEPTH)) || pop_s);
      rd_next_s   = rd_ptr_r + PW'(pop_s);
      avail_s     = count_r - CW'(pop_s);
      drained_s   = (hold_full_r == {NUM_CORES{1'b0}}) && (count_r == {CW{1'b0}});
      push_data_s = 8'd0;
      freed_s     = {NUM_CORES{1'b0}};
      if (grant_idx_s == 6'(NUM_CORES - 1)) begin
         rr_next_s = 6'd0;
      end else begin
         rr_next_s = grant_idx_s + 6'd1;
      end
      for (int i = 0; i < NUM_CORES; i++) begin
         if (grant_idx_s == 6'(i)) begin
            push_data_s = hold_data_r[i];
            freed_s[i]  = push_s;
         end else begin
            freed_s[i]  = 1'b0;
         end
      end
   end

   // Watchdog next value: clear on any retire, otherwise saturating increment
   always_comb begin
      if (any_valid_s) begin
         wd_next_s = 32'd0;
      end else if (wd_cnt_r == 32'hFFFF_FFFF) begin
         wd_next_s = wd_cnt_r;
      end else begin
         wd_next_s = wd_cnt_r + 32'd1;
      end
      wd_fire_s = (TIMEOUT_CYCLES != 0) && (wd_next_s >= 32'(TIMEOUT_CYCLES));
   end

   // Shadow x3 per core and capture the exit code on the first exit marker only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            shadow_r[i] <= 8'd0;
         end
         core_done_r <= {NUM_CORES{1'b0}};
         exit_code_r <= {(NUM_CORES*8){1'b0}};
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (trace_valid[i] && trace_wben[i] && (trace_wbreg[i*5 +: 5] == 5'd3)) begin
               shadow_r[i] <= trace_wbdata[i*XLEN +: 8];
            end
            if (exit_s[i] && !core_done_r[i]) begin
               core_done_r[i]         <= 1'b1;
               exit_code_r[i*8 +: 8]  <= shadow_r[i];
            end
         end
      end
   end

   // Per-core putc hold registers, overflow flag and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_full_r     <= {NUM_CORES{1'b0}};
         char_overflow_r <= 1'b0;
         rr_ptr_r        <= 6'd0;
         for (int i = 0; i < NUM_CORES; i++) begin
            hold_data_r[i] <= 8'd0;
         end
      end else begin
         if (push_s) begin
            rr_ptr_r <= rr_next_s;
         end
         for (int i = 0; i < NUM_CORES; i++) begin
            if (putc_s[i]) begin
               // A hold register emptied into the FIFO this cycle can take a new char
               if (!hold_full_r[i] || freed_s[i]) begin
                  hold_full_r[i] <= 1'b1;
                  hold_data_r[i] <= shadow_r[i];
               end else begin
                  char_overflow_r <= 1'b1;
               end
            end else if (freed_s[i]) begin
               hold_full_r[i] <= 1'b0;
            end
         end
      end
   end

   // Character FIFO storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= {grant_idx_s, push_data_s};
      end
   end

   // FIFO pointers, occupancy and registered head; the head entry stays counted until popped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r     <= {PW{1'b0}};
         rd_ptr_r     <= {PW{1'b0}};
         count_r      <= {CW{1'b0}};
         char_valid_r <= 1'b0;
         char_core_r  <= 6'd0;
         char_data_r  <= 8'd0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         rd_ptr_r <= rd_next_s;
         count_r  <= count_r + CW'(push_s) - CW'(pop_s);
         if (avail_s != {CW{1'b0}}) begin
            char_valid_r               <= 1'b1;
            {char_core_r, char_data_r} <= fifo_mem_r[rd_next_s];
         end else begin
            char_valid_r <= 1'b0;
         end
      end
   end

   // Run-state FSM with watchdog and registered completion flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         wd_cnt_r     <= 32'd0;
         all_done_r   <= 1'b0;
         exit_error_r <= 1'b0;
         timeout_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               wd_cnt_r <= 32'd0;
               if (any_valid_s) begin
                  state_r <= ST_RUN;
               end
            end
            ST_RUN, ST_DRAIN: begin
               wd_cnt_r <= wd_next_s;
               if (wd_fire_s) begin
                  timeout_r <= 1'b1;
                  state_r   <= ST_TIMEOUT;
               end else if ((state_r == ST_RUN) && (&core_done_r)) begin
                  state_r <= ST_DRAIN;
               end else if ((state_r == ST_DRAIN) && drained_s) begin
                  state_r      <= ST_DONE;
                  all_done_r   <= 1'b1;
                  exit_error_r <= |exit_code_r;
               end
            end
            ST_DONE, ST_TIMEOUT: begin
               state_r <= state_r;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign char_valid    = char_valid_r;
   assign char_core     = char_core_r;
   assign char_data     = char_data_r;
   assign core_done     = core_done_r;
   assign exit_code     = exit_code_r;
   assign all_done      = all_done_r;
   assign exit_error    = exit_error_r;
   assign char_overflow = char_overflow_r;
   assign timeout       = timeout_r;

endmodule
